uart_rx_cfg: RTL and testbench

Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Adds configurable data width, parity, stop-bit count, an input synchroniser and distinct framing/parity/break error reporting. Sits between the async rx pin and the host-side RX FIFO. Output is a single-cycle valid pulse per frame.

---
 rtl/uart_rx_cfg.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with configurable data width,
// parity, stop-bit count, an input synchroniser and separate framing,
// parity and break reporting. Each frame produces one single-cycle pulse.
// Optional build macro UART_RX_MAJORITY_EN: every sample tick takes the
// majority of the last three synchronised line values.
module uart_rx_cfg #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 busy
);

  localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int HALF    = DIVISOR / 2;
  localparam int CW      = $clog2(DIVISOR) + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1    = CW'(DIVISOR - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx;
  logic                   samp;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err;
  logic                   frame_err;
  logic                   any_one;

  // Metastability synchroniser for the asynchronous serial line
  always_ff @(posedge clk) begin
    if (!rst_) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
  end

  assign rx = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] maj_q;

  // History of the last three synchronised values for glitch rejection
  always_ff @(posedge clk) begin
    if (!rst_) maj_q <= '1;
    else       maj_q <= {maj_q[1:0], rx};
  end

  assign samp = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
`else
  assign samp = rx;
`endif

  // Frame FSM: bit-centre sampling, error tracking and registered output pulses
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_err       <= 1'b0;
      frame_err     <= 1'b0;
      any_one       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!samp) begin
              state     <= S_DATA;
              bit_cnt   <= '0;
              par_err   <= 1'b0;
              frame_err <= 1'b0;
              any_one   <= 1'b0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt == BIT_M1) begin
            cnt     <= '0;
            shreg   <= {samp, shreg[DATA_BITS-1:1]};
            any_one <= any_one | samp;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_PARITY: begin
          if (cnt == BIT_M1) begin
            cnt     <= '0;
            any_one <= any_one | samp;
            // Odd expects an XOR of 1, even expects 0; the difference flags a mismatch.
            par_err <= (^shreg) ^ samp ^ (PARITY == 1);
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              // Leave at the centre of the last stop bit so the next start edge is caught.
              bit_cnt <= '0;
              if (frame_err || !samp) begin
                rx_frame_err <= 1'b1;
                rx_break     <= !(any_one || samp);
                state        <= S_WAIT_HIGH;
              end else begin
                rx_valid      <= 1'b1;
                rx_data       <= shreg;
                rx_parity_err <= par_err;
                state         <= S_IDLE;
                busy          <= 1'b0;
              end
            end else begin
              frame_err <= frame_err | !samp;
              any_one   <= any_one | samp;
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_WAIT_HIGH: begin
          cnt <= '0;
          if (rx) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) on a
// shared clock and reset, each with its own serial line and pulse monitor.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic line0 = 1'b1, line1 = 1'b1, line2 = 1'b1;

  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic valid0, perr0, ferr0, brk0, busy0;
  logic valid1, perr1, ferr1, brk1, busy1;
  logic valid2, perr2, ferr2, brk2, busy2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_8n1 (
    .clk(clk), .rst_(rst_), .rx_serial(line0), .rx_data(data0), .rx_valid(valid0),
    .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_break(brk0), .busy(busy0));

  uart_rx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_8e1 (
    .clk(clk), .rst_(rst_), .rx_serial(line1), .rx_data(data1), .rx_valid(valid1),
    .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_break(brk1), .busy(busy1));

  uart_rx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(2)) u_7o2 (
    .clk(clk), .rst_(rst_), .rx_serial(line2), .rx_data(data2), .rx_valid(valid2),
    .rx_parity_err(perr2), .rx_frame_err(ferr2), .rx_break(brk2), .busy(busy2));

  logic [2:0] vv, pp, ff, bb;
  logic [2:0] prev_v = '0;
  logic [8:0] dd [3];
  logic [8:0] last [3];
  int vcnt [3], pecnt [3], fecnt [3], bkcnt [3], dbl [3], stray [3];

  assign vv = {valid2, valid1, valid0};
  assign pp = {perr2, perr1, perr0};
  assign ff = {ferr2, ferr1, ferr0};
  assign bb = {brk2, brk1, brk0};
  assign dd[0] = {1'b0, data0};
  assign dd[1] = {1'b0, data1};
  assign dd[2] = {2'b00, data2};

  initial begin
    for (int d = 0; d < 3; d++) begin
      vcnt[d] = 0; pecnt[d] = 0; fecnt[d] = 0; bkcnt[d] = 0;
      dbl[d] = 0; stray[d] = 0; last[d] = '0;
    end
  end

  // Pulse monitor: counts pulses, captures delivered words, flags illegal combinations
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vv[d]) begin
        vcnt[d]++;
        last[d] = dd[d];
        if (prev_v[d]) dbl[d]++;
      end
      if (pp[d]) begin
        if (vv[d]) pecnt[d]++;
        else stray[d]++;
      end
      if (ff[d]) begin
        fecnt[d]++;
        if (vv[d]) stray[d]++;
      end
      if (bb[d]) begin
        if (ff[d]) bkcnt[d]++;
        else stray[d]++;
      end
    end
    prev_v = vv;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int d, input logic b);
    case (d)
      0:       line0 = b;
      1:       line1 = b;
      default: line2 = b;
    endcase
  endtask

  // Drive n bits LSB first, one bit time (10 clocks) each
  task automatic send_bits(input int d, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(d, bits[i]);
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  v_s, f_s, b_s, p_s;
    logic seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data0", {24'd0, data0}, 32'h0);
    check("rst_flags0", {27'd0, valid0, perr0, ferr0, brk0, busy0}, 32'h0);
    check("rst_flags2", {27'd0, valid2, perr2, ferr2, brk2, busy2}, 32'h0);
    rst_ = 1'b1;
    idle(5);

    // 1: back-to-back 8N1 frames
    send_bits(0, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10);
    check("t1_first_data", {23'd0, last[0]}, 32'hA5);
    send_bits(0, {6'h3F, 1'b1, 8'h3C, 1'b0}, 10);
    idle(30);
    check("t1_valid_cnt", vcnt[0], 2);
    check("t1_second_data", {23'd0, last[0]}, 32'h3C);
    check("t1_no_errors", pecnt[0] + fecnt[0] + bkcnt[0], 0);
    check("t1_single_cycle", dbl[0], 0);

    // 2: even parity, wrong parity bit; data still delivered
    send_bits(1, {5'h1F, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    idle(30);
    check("t2_valid_cnt", vcnt[1], 1);
    check("t2_perr_with_valid", pecnt[1], 1);
    check("t2_data", {23'd0, last[1]}, 32'h3C);
    check("t2_no_ferr", fecnt[1], 0);

    // 3: stop bit low, not a break
    send_bits(0, {6'h3F, 1'b0, 8'h55, 1'b0}, 10);
    set_line(0, 1'b1);
    idle(30);
    check("t3_ferr_cnt", fecnt[0], 1);
    check("t3_no_valid", vcnt[0], 2);
    check("t3_data_held", {24'd0, data0}, 32'h3C);
    check("t3_no_break", bkcnt[0], 0);

    // 4: held break, then a normal frame
    v_s = vcnt[0]; f_s = fecnt[0]; b_s = bkcnt[0];
    set_line(0, 1'b0);
    idle(20);
    check("t4_busy_early", {31'd0, busy0}, 32'h1);
    idle(129);
    check("t4_busy_held", {31'd0, busy0}, 32'h1);
    idle(1);
    set_line(0, 1'b1);
    idle(10);
    check("t4_busy_released", {31'd0, busy0}, 32'h0);
    check("t4_one_ferr", fecnt[0] - f_s, 1);
    check("t4_one_break", bkcnt[0] - b_s, 1);
    idle(20);
    send_bits(0, {6'h3F, 1'b1, 8'h0F, 1'b0}, 10);
    idle(30);
    check("t4_valid_after", vcnt[0] - v_s, 1);
    check("t4_data", {23'd0, last[0]}, 32'h0F);

    // 5: 7O2, second stop bit low, then clean resend
    send_bits(2, {5'h1F, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 11);
    set_line(2, 1'b1);
    idle(30);
    check("t5_ferr", fecnt[2], 1);
    check("t5_no_valid", vcnt[2], 0);
    check("t5_no_break", bkcnt[2], 0);
    send_bits(2, {5'h1F, 1'b1, 1'b1, 1'b1, 7'h41, 1'b0}, 11);
    idle(30);
    check("t5_valid", vcnt[2], 1);
    check("t5_data", {23'd0, last[2]}, 32'h41);
    check("t5_no_perr", pecnt[2], 0);

    // 6: short glitch, then reset mid-frame, then a good frame
    v_s = vcnt[0]; f_s = fecnt[0]; p_s = pecnt[0];
    seen = 1'b0;
    set_line(0, 1'b0);
    repeat (3) begin @(negedge clk); if (busy0) seen = 1'b1; end
    set_line(0, 1'b1);
    repeat (20) begin @(negedge clk); if (busy0) seen = 1'b1; end
    check("t6_glitch_busy_seen", {31'd0, seen}, 32'h1);
    check("t6_glitch_busy_clear", {31'd0, busy0}, 32'h0);
    check("t6_glitch_no_pulses", (vcnt[0] - v_s) + (fecnt[0] - f_s) + (pecnt[0] - p_s), 0);

    fork
      send_bits(0, {6'h3F, 1'b1, 8'hFF, 1'b0}, 10);
      begin
        idle(45);
        check("t6_busy_in_data", {31'd0, busy0}, 32'h1);
        rst_ = 1'b0;
        @(negedge clk);
        check("t6_rst_data", {24'd0, data0}, 32'h0);
        check("t6_rst_flags", {27'd0, valid0, perr0, ferr0, brk0, busy0}, 32'h0);
        rst_ = 1'b1;
      end
    join
    idle(20);
    check("t6_no_pulse_after_abort", (vcnt[0] - v_s) + (fecnt[0] - f_s), 0);
    send_bits(0, {6'h3F, 1'b1, 8'h81, 1'b0}, 10);
    idle(30);
    check("t6_valid", vcnt[0] - v_s, 1);
    check("t6_data", {23'd0, last[0]}, 32'h81);

    check("all_single_cycle", dbl[0] + dbl[1] + dbl[2], 0);
    check("all_no_stray", stray[0] + stray[1] + stray[2], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
